// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird score path: widths, segment
// patterns for the active-low HEX digits and the display FSM state type.
package flappy_pkg;

  localparam int SCORE_W = 10;
  localparam int DIGITS  = 4;
  localparam int BCD_W   = 4 * DIGITS;
  localparam int CNT_W   = $clog2(SCORE_W + 1);

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, LATCH} disp_state_t;

  // Double-dabble correction: any BCD nibble of 5 or more gets +3 so the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [BCD_W-1:0] add3_nibbles(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] r;
    r = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// One BCD digit to active-low seven-segment pattern, with a blank override
// used for leading-zero suppression. Non-decimal nibbles show blank.
module seg7_decode
  import flappy_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Pure lookup; blank wins over the digit value.
  always_comb begin
    seg = SEG_BLANK;
    if (!blank) begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/score_display_driver.sv
// Converts the live score (or the session high score) to decimal with a
// sequential double-dabble engine and drives four active-low HEX digits.
// The display only ever shows a completed conversion held in shown_bcd.
module score_display_driver
  import flappy_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic [SCORE_W-1:0] score,
  input  logic               show_high,
  output logic               busy,
  output logic [SCORE_W-1:0] high_score,
  output logic [6:0]         hex0,
  output logic [6:0]         hex1,
  output logic [6:0]         hex2,
  output logic [6:0]         hex3
);

  disp_state_t        state;
  disp_state_t        next_state;
  logic [SCORE_W-1:0] src;
  logic [SCORE_W-1:0] last_src;
  logic [SCORE_W-1:0] bin_sr;
  logic [BCD_W-1:0]   bcd_sr;
  logic [BCD_W-1:0]   bcd_adj;
  logic [BCD_W-1:0]   shown_bcd;
  logic [CNT_W-1:0]   cnt;
  logic [DIGITS-1:0]  blank;
  logic [6:0]         seg [DIGITS];

  assign src     = show_high ? high_score : score;
  assign busy    = (state != IDLE);
  assign bcd_adj = add3_nibbles(bcd_sr);

  // Running maximum of the live score; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      high_score <= '0;
    end else if (score > high_score) begin
      high_score <= score;
    end
  end

  // Display FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state: a conversion starts only from IDLE, so src changes while
  // busy are picked up by the last_src compare once the engine is free.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (src != last_src) next_state = LOAD;
      LOAD:    next_state = SHIFT;
      SHIFT:   if (cnt == CNT_W'(1)) next_state = LATCH;
      LATCH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Double-dabble datapath and the held result; shown_bcd changes only in
  // LATCH so a reset or a pending change never exposes a partial value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bin_sr    <= '0;
      bcd_sr    <= '0;
      cnt       <= '0;
      last_src  <= '0;
      shown_bcd <= '0;
    end else begin
      case (state)
        LOAD: begin
          bin_sr   <= src;
          bcd_sr   <= '0;
          cnt      <= CNT_W'(SCORE_W);
          last_src <= src;
        end
        SHIFT: begin
          {bcd_sr, bin_sr} <= {bcd_adj[BCD_W-2:0], bin_sr, 1'b0};
          cnt              <= cnt - CNT_W'(1);
        end
        LATCH: begin
          shown_bcd <= bcd_sr;
        end
        default: begin
        end
      endcase
    end
  end

  // Leading-zero blanking: a digit above the ones place is blank when it
  // and every digit above it are zero. The ones digit always shows.
  always_comb begin
    logic upper_zero;
    blank      = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero = upper_zero && (shown_bcd[4*i +: 4] == 4'd0);
      blank[i]   = upper_zero;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    seg7_decode u_seg (
      .digit (shown_bcd[4*g +: 4]),
      .blank (blank[g]),
      .seg   (seg[g])
    );
  end

  assign hex0 = seg[0];
  assign hex1 = seg[1];
  assign hex2 = seg[2];
  assign hex3 = seg[3];

endmodule

// File: tb/tb_score_display_driver.sv
// Directed bench for score_display_driver. Expected HEX patterns come from a
// decimal-division model and are queued when a source change is driven.
module tb_score_display_driver;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] score = '0;
  logic       show_high = 1'b0;
  logic       busy;
  logic [9:0] high_score;
  logic [6:0] hex0, hex1, hex2, hex3;

  int          compared = 0;
  int          mismatched = 0;
  int          model_high = 0;
  logic [27:0] sb [$];
  logic [27:0] last_shown;

  score_display_driver dut (
    .clk        (clk),
    .reset      (reset),
    .score      (score),
    .show_high  (show_high),
    .busy       (busy),
    .high_score (high_score),
    .hex0       (hex0),
    .hex1       (hex1),
    .hex2       (hex2),
    .hex3       (hex3)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // {hex3,hex2,hex1,hex0} expected for a value, with leading-zero blanking.
  function automatic logic [27:0] expect_hex(input int v);
    int d0, d1, d2, d3;
    logic [6:0] s3, s2, s1;
    d0 = v % 10;
    d1 = (v / 10) % 10;
    d2 = (v / 100) % 10;
    d3 = v / 1000;
    s3 = (d3 == 0) ? 7'b1111111 : seg_of(d3);
    s2 = (d3 == 0 && d2 == 0) ? 7'b1111111 : seg_of(d2);
    s1 = (d3 == 0 && d2 == 0 && d1 == 0) ? 7'b1111111 : seg_of(d1);
    return {s3, s2, s1, seg_of(d0)};
  endfunction

  function automatic logic [27:0] hex_now();
    return {hex3, hex2, hex1, hex0};
  endfunction

  task automatic compareValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive new inputs on a falling edge and queue the value the display must reach.
  task automatic applyStimulus(input int new_score, input logic new_show);
    @(negedge clk);
    score     = 10'(new_score);
    show_high = new_show;
    if (new_score > model_high) model_high = new_score;
    sb.push_back(expect_hex(new_show ? model_high : new_score));
  endtask

  // Wait (bounded) for the engine to go idle, then pop and compare. Every
  // sample on the way must be the previous or the final display value.
  task automatic checkOutput(input string tag, input int skip);
    int          n;
    logic        coherent;
    logic [27:0] exp;
    repeat (skip) @(negedge clk);
    n        = 0;
    coherent = 1'b1;
    exp      = (sb.size() > 0) ? sb[0] : 28'h0;
    while (busy !== 1'b0 && n < 40) begin
      if (hex_now() !== last_shown && hex_now() !== exp) coherent = 1'b0;
      @(negedge clk);
      n++;
    end
    compareValue({tag, "_settle"}, 32'(n < 40), 32'd1);
    compareValue({tag, "_queued"}, 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) exp = sb.pop_front();
    compareValue({tag, "_hex"}, 32'(hex_now()), 32'(exp));
    compareValue({tag, "_coherent"}, 32'(coherent), 32'd1);
    last_shown = exp;
  endtask

  initial begin
    last_shown = expect_hex(0);

    // Reset values appear asynchronously, before any clock edge.
    #1 reset = 1'b0;
    #2;
    compareValue("rst_hex", 32'(hex_now()), 32'(expect_hex(0)));
    compareValue("rst_busy", 32'(busy), 32'd0);
    compareValue("rst_high", 32'(high_score), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compareValue("idle_busy", 32'(busy), 32'd0);
    compareValue("idle_hex", 32'(hex_now()), 32'(expect_hex(0)));

    // 0 -> 7: busy next cycle, old display through 12 edges, new after.
    applyStimulus(7, 1'b0);
    @(negedge clk);
    compareValue("t2_busy_rise", 32'(busy), 32'd1);
    repeat (11) @(negedge clk);
    compareValue("t2_hold_old", 32'(hex_now()), 32'(expect_hex(0)));
    compareValue("t2_busy_latch", 32'(busy), 32'd1);
    checkOutput("t2", 0);
    compareValue("t2_busy_fall", 32'(busy), 32'd0);

    // Largest score: all four digits lit.
    applyStimulus(1023, 1'b0);
    checkOutput("t3", 1);
    compareValue("t3_high", 32'(high_score), 32'(model_high));

    // Change arriving mid-conversion is converted afterwards.
    applyStimulus(5, 1'b0);
    repeat (4) @(negedge clk);
    applyStimulus(6, 1'b0);
    checkOutput("t4_first", 0);
    checkOutput("t4_second", 1);

    // Reset mid-SHIFT aborts the conversion and clears everything.
    applyStimulus(900, 1'b0);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    score = '0;
    #1;
    compareValue("t6_hex", 32'(hex_now()), 32'(expect_hex(0)));
    compareValue("t6_busy", 32'(busy), 32'd0);
    compareValue("t6_high", 32'(high_score), 32'd0);
    sb.delete();
    model_high = 0;
    last_shown = expect_hex(0);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    compareValue("t6_after_busy", 32'(busy), 32'd0);
    compareValue("t6_after_hex", 32'(hex_now()), 32'(expect_hex(0)));

    // High score view survives the live score falling back to 0.
    applyStimulus(42, 1'b0);
    checkOutput("t5_42", 1);
    applyStimulus(0, 1'b0);
    checkOutput("t5_zero", 1);
    compareValue("t5_high", 32'(high_score), 32'd42);
    applyStimulus(0, 1'b1);
    checkOutput("t5_show_high", 1);
    applyStimulus(0, 1'b0);
    checkOutput("t5_show_live", 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
